// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// One operation at a time through a start/busy/done handshake. Multiplies use
// shift-add and divides use restoring division, one bit per cycle over 32
// cycles, followed by a sign-correction/result-select cycle. Divide-by-zero and
// signed overflow skip the iteration and complete one cycle after accept.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic            iStart,
  input  logic            iFlush,
  input  logic [2:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [4:0]   r_cnt;
  logic [2:0]   r_op;
  logic         r_neg_q;    // product / quotient sign
  logic         r_neg_r;    // remainder sign
  logic         r_special;  // r_rem holds a preloaded final answer
  // Multiply: {accumulator, multiplier}. Divide: low half is dividend/quotient.
  logic [63:0]  r_prod;
  logic [31:0]  r_b;
  logic [31:0]  r_rem;
  logic         r_done;
  logic [31:0]  r_result;

  // Request decode and operand conditioning at the accepting edge
  logic         w_accept;
  logic         w_a_signed;
  logic         w_b_signed;
  logic         w_sa;
  logic         w_sb;
  logic [31:0]  w_mag_a;
  logic [31:0]  w_mag_b;
  logic         w_div_zero;
  logic         w_overflow;
  logic         w_special;
  logic [31:0]  w_spec_res;

  assign w_accept   = (r_state == S_IDLE) && iStart && !iFlush;
  assign w_a_signed = (iOp == 3'd1) || (iOp == 3'd2) || (iOp == 3'd4) || (iOp == 3'd6);
  assign w_b_signed = (iOp == 3'd1) || (iOp == 3'd4) || (iOp == 3'd6);
  assign w_sa       = w_a_signed && iA[31];
  assign w_sb       = w_b_signed && iB[31];
  assign w_mag_a    = w_sa ? (~iA + 32'd1) : iA;
  assign w_mag_b    = w_sb ? (~iB + 32'd1) : iB;
  assign w_div_zero = iOp[2] && (iB == 32'd0);
  // Only DIV/REM (op bit0 clear) are signed divides.
  assign w_overflow = iOp[2] && !iOp[0] && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
  assign w_special  = w_div_zero || w_overflow;
  // iOp[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
  assign w_spec_res = w_div_zero ? (iOp[1] ? iA : 32'hFFFF_FFFF)
                                 : (iOp[1] ? 32'd0 : 32'h8000_0000);

  // One iteration step for each algorithm
  logic [32:0]  w_mul_sum;
  logic [63:0]  w_mul_next;
  logic [32:0]  w_trial;
  logic [32:0]  w_diff;
  logic         w_ge;
  logic [31:0]  w_rem_next;

  assign w_mul_sum  = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_prod[31:1]};
  assign w_trial    = {r_rem, r_prod[31]};
  assign w_diff     = w_trial - {1'b0, r_b};
  assign w_ge       = (w_trial >= {1'b0, r_b});
  assign w_rem_next = w_ge ? w_diff[31:0] : w_trial[31:0];

  // Sign correction and result selection for the FIX cycle
  logic [63:0]  w_prod_fix;
  logic [31:0]  w_quot_fix;
  logic [31:0]  w_rem_fix;
  logic [31:0]  w_fix_res;

  assign w_prod_fix = r_neg_q ? (~r_prod + 64'd1) : r_prod;
  assign w_quot_fix = r_neg_q ? (~r_prod[31:0] + 32'd1) : r_prod[31:0];
  assign w_rem_fix  = r_neg_r ? (~r_rem + 32'd1) : r_rem;

  // Pick the architectural result; preloaded special answers bypass correction
  always_comb begin
    w_fix_res = 32'd0;
    if (r_special) begin
      w_fix_res = r_rem;
    end else begin
      case (r_op)
        3'd0:                w_fix_res = w_prod_fix[31:0];
        3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_fix[63:32];
        3'd4, 3'd5:          w_fix_res = w_quot_fix;
        default:             w_fix_res = w_rem_fix;
      endcase
    end
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = w_special ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == 5'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (iFlush) w_state_next = S_IDLE;
  end

  // Operand capture and per-cycle iteration datapath
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_cnt     <= 5'd0;
      r_op      <= 3'd0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_prod    <= 64'd0;
      r_b       <= 32'd0;
      r_rem     <= 32'd0;
    end else if (w_accept) begin
      r_cnt     <= 5'd0;
      r_op      <= iOp;
      r_neg_q   <= w_sa ^ w_sb;
      r_neg_r   <= w_sa;
      r_special <= w_special;
      r_prod    <= {32'd0, w_mag_a};
      r_b       <= w_mag_b;
      r_rem     <= w_special ? w_spec_res : 32'd0;
    end else if ((r_state == S_CALC) && !iFlush) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_op[2]) begin
        r_rem         <= w_rem_next;
        r_prod[31:0]  <= {r_prod[30:0], w_ge};
      end else begin
        r_prod <= w_mul_next;
      end
    end
  end

  // Completion: load the result and pulse done unless the FIX cycle is flushed
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= (r_state == S_FIX) && !iFlush;
      if ((r_state == S_FIX) && !iFlush) r_result <= w_fix_res;
    end
  end

  assign oBusy   = (r_state != S_IDLE);
  assign oDone   = r_done;
  assign oResult = r_result;

endmodule
